bus_arbiter_2m: RTL and testbench
=================================

# bus_arbiter_2m

Two-master round-robin arbiter that produces the one-hot `grant` consumed by the two-master-to-one-slave bus mux. It watches both masters' `req` lines and the slave's `ack`, and hands bus ownership over only at transaction boundaries. A watchdog releases the bus from a master whose transaction is never acknowledged. Grant is registered and parked on the last owner, so the mux never sees a spurious `2'b00` mid-stream.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles a granted request may wait for `ack` before forced release; 0 disables the watchdog.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_in_first`  in  1  request from master 1 (held until acked)
- `req_in_second`  in  1  request from master 2
- `ack_out`  in  1  one-cycle acknowledge from slave (mux output side)
- `grant`  out  2  `2'b10` = master 1 owns bus, `2'b01` = master 2, `2'b00` = no owner
- `busy`  out  1  owner's `req` is high and not yet acked this cycle
- `timeout_err`  out  1  one-cycle pulse on forced release
- `timeout_id`  out  2  grant code of the master released by the last timeout; held until next timeout

## Operation
- States: IDLE (`grant=00`), OWN_FIRST (`10`), OWN_SECOND (`01`). `grant` is a registered decode of state.
- IDLE: if only one master requests, move to its state. If both request, move to OWN_FIRST (reset priority). Otherwise stay.
- OWN_X, transaction active (`req_X`=1):
  - `ack_out`=1 ends the transaction.
  - On that edge, if the other master requests, move to OWN_other. Otherwise stay (park).
  - Never leave mid-transaction except on timeout.
- OWN_X, `req_X`=0: if the other master requests, move to OWN_other next edge. Otherwise stay parked. Never return to IDLE except via reset.
- Round-robin: after completing a transaction, a master with the other side requesting always yields. A lone requester may be served back-to-back indefinitely.
- `ack_out` while owner's `req`=0 is ignored (no state change, no counter effect).
- Watchdog:
  - `wd_cnt` width `$clog2(TIMEOUT+1)`. It clears on any state change, on `ack_out`, or when owner `req`=0. It increments while owner `req`=1 and `ack_out`=0.
  - When `wd_cnt==TIMEOUT-1` and no ack this cycle, the next edge does three things:
    - pulse `timeout_err`;
    - load `timeout_id` with the current grant;
    - move to OWN_other if the other requests, else stay and clear `wd_cnt`.
  - Counter saturates; it never wraps.

## Timing
- Reset values: `grant=00`, `busy=0`, `timeout_err=0`, `timeout_id=00`, `wd_cnt=0`, state IDLE.
- Request-to-grant latency from IDLE: 1 cycle. `req` sampled at edge N gives `grant` valid after edge N.
- Hand-off latency: `grant` changes on the same edge that samples `ack_out`=1. The new owner's request is presented to the slave in the cycle after the ack.
- `busy` is combinational: `state!=IDLE` and owner `req` and not `ack_out`.
- Simultaneous `ack_out` and timeout threshold: ack wins, and no error is raised.
- `rst_n` low mid-transaction: outputs go to reset values immediately (asynchronous). Deassertion is synchronised externally.

## Structure
- Package `bus_pkg`:
  - grant encodings `GNT_NONE=2'b00`, `GNT_FIRST=2'b10`, `GNT_SECOND=2'b01`;
  - state enum `arb_state_t`.
  The mux consumes the same constants.
- Single module, no sub-modules. The watchdog counter is inline.

## Test plan
- Reset: hold `rst_n`=0 with both reqs high → `grant=00`, all outputs 0. Release → `grant=10` one edge later.
- Lone master 2: `req_in_second`=1, `ack_out` at cycle 3, keep req high → `grant=01` throughout, two back-to-back transactions, no `00`.
- Contention: both reqs high, ack every 2nd cycle → grant alternates `10,01,10,01`. Each switch happens on the ack edge.
- Parking: master 1 finishes and drops req, nobody requests → `grant` stays `10`. Then master 2 requests → `01` next edge.
- Timeout (`TIMEOUT=4`): master 1 req high, master 2 requesting, no ack → after 4 cycles `timeout_err` pulses once, `timeout_id=10`, `grant=01`.
- Ack on threshold cycle (`TIMEOUT=4`): ack arrives in the 4th waiting cycle → no `timeout_err`, normal hand-off. `TIMEOUT=0`: never errors over 1000 cycles.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - grant encodings and arbiter state type shared by the arbiter and the bus mux
package bus_pkg;

  localparam logic [1:0] GNT_NONE   = 2'b00;
  localparam logic [1:0] GNT_FIRST  = 2'b10;
  localparam logic [1:0] GNT_SECOND = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_OWN_FIRST  = 2'd1,
    ST_OWN_SECOND = 2'd2
  } arb_state_t;

  function automatic logic [1:0] grant_of(arb_state_t s);
    case (s)
      ST_OWN_FIRST:  grant_of = GNT_FIRST;
      ST_OWN_SECOND: grant_of = GNT_SECOND;
      default:       grant_of = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter_2m.sv
// rtl/bus_arbiter_2m.sv - two-master round-robin bus arbiter with parked grant and ack watchdog
module bus_arbiter_2m
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_in_first,
  input  logic       req_in_second,
  input  logic       ack_out,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] timeout_id
);

  // A zero-width counter is illegal, so the disabled watchdog keeps one idle bit.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_ON = (TIMEOUT > 0);

  arb_state_t      state_q, state_d, other_state;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            owner_req, other_req, timeout_hit;

  always_comb begin
    state_d     = state_q;
    owner_req   = 1'b0;
    other_req   = 1'b0;
    other_state = ST_OWN_FIRST;
    case (state_q)
      ST_OWN_FIRST: begin
        owner_req   = req_in_first;
        other_req   = req_in_second;
        other_state = ST_OWN_SECOND;
      end
      ST_OWN_SECOND: begin
        owner_req   = req_in_second;
        other_req   = req_in_first;
        other_state = ST_OWN_FIRST;
      end
      default: begin
        if (req_in_first)
          state_d = ST_OWN_FIRST;
        else if (req_in_second)
          state_d = ST_OWN_SECOND;
      end
    endcase

    // Ack takes precedence over the threshold, so a late ack never raises an error.
    timeout_hit = WD_ON && owner_req && !ack_out && (wd_q == WD_LAST);

    if (state_q != ST_IDLE && other_req && (!owner_req || ack_out || timeout_hit))
      state_d = other_state;

    busy = owner_req && !ack_out;

    wd_d = wd_q;
    if (state_d != state_q || ack_out || !owner_req || timeout_hit)
      wd_d = '0;
    else if (wd_q != '1)
      wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant       <= GNT_NONE;
      wd_q        <= '0;
      timeout_err <= 1'b0;
      timeout_id  <= GNT_NONE;
    end else begin
      state_q     <= state_d;
      grant       <= grant_of(state_d);
      wd_q        <= wd_d;
      timeout_err <= timeout_hit;
      if (timeout_hit)
        timeout_id <= grant;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb/tb_bus_arbiter_2m.sv - directed vector bench for bus_arbiter_2m
module tb_bus_arbiter_2m;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_in_first = 1'b0;
  logic       req_in_second = 1'b0;
  logic       ack_out = 1'b0;
  logic [1:0] grant, grant0;
  logic       busy, busy0;
  logic       timeout_err, timeout_err0;
  logic [1:0] timeout_id, timeout_id0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_arbiter_2m #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_in_first(req_in_first), .req_in_second(req_in_second), .ack_out(ack_out),
    .grant(grant), .busy(busy), .timeout_err(timeout_err), .timeout_id(timeout_id)
  );

  bus_arbiter_2m #(.TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_in_first(req_in_first), .req_in_second(req_in_second), .ack_out(ack_out),
    .grant(grant0), .busy(busy0), .timeout_err(timeout_err0), .timeout_id(timeout_id0)
  );

  // busy is checked before the edge; grant/err/id after it.
  typedef struct {
    logic       r1;
    logic       r2;
    logic       ack;
    logic       busy;
    logic [1:0] grant;
    logic       err;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[33];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r1, input logic r2, input logic a);
    @(negedge clk);
    req_in_first  = r1;
    req_in_second = r2;
    ack_out       = a;
  endtask

  initial begin
    int errs0;
    vecs = '{
      // lone master 2, two back-to-back transactions
      '{0,1,0, 0,2'b01,0,2'b00},
      '{0,1,0, 1,2'b01,0,2'b00},
      '{0,1,1, 0,2'b01,0,2'b00},
      '{0,1,0, 1,2'b01,0,2'b00},
      '{0,1,1, 0,2'b01,0,2'b00},
      '{0,0,0, 0,2'b01,0,2'b00},
      // contention, ack every second cycle
      '{1,1,0, 1,2'b01,0,2'b00},
      '{1,1,1, 0,2'b10,0,2'b00},
      '{1,1,0, 1,2'b10,0,2'b00},
      '{1,1,1, 0,2'b01,0,2'b00},
      '{1,1,0, 1,2'b01,0,2'b00},
      '{1,1,1, 0,2'b10,0,2'b00},
      // parking on master 1, stray ack ignored, then master 2 takes over
      '{1,0,0, 1,2'b10,0,2'b00},
      '{1,0,1, 0,2'b10,0,2'b00},
      '{0,0,0, 0,2'b10,0,2'b00},
      '{0,0,1, 0,2'b10,0,2'b00},
      '{0,1,0, 0,2'b01,0,2'b00},
      '{1,1,1, 0,2'b10,0,2'b00},
      // timeout on master 1 with master 2 waiting
      '{1,1,0, 1,2'b10,0,2'b00},
      '{1,1,0, 1,2'b10,0,2'b00},
      '{1,1,0, 1,2'b10,0,2'b00},
      '{1,1,0, 1,2'b01,1,2'b10},
      // ack on the threshold cycle wins
      '{1,1,0, 1,2'b01,0,2'b10},
      '{1,1,0, 1,2'b01,0,2'b10},
      '{1,1,0, 1,2'b01,0,2'b10},
      '{1,1,1, 0,2'b10,0,2'b10},
      // lone master 2 times out and stays parked
      '{0,1,0, 0,2'b01,0,2'b10},
      '{0,1,0, 1,2'b01,0,2'b10},
      '{0,1,0, 1,2'b01,0,2'b10},
      '{0,1,0, 1,2'b01,0,2'b10},
      '{0,1,0, 1,2'b01,1,2'b01},
      '{0,1,0, 1,2'b01,0,2'b01},
      '{0,0,0, 0,2'b01,0,2'b01}
    };

    // reset held with both requests high
    req_in_first  = 1'b1;
    req_in_second = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_id", timeout_id, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_grant", grant, 2'b10);

    // asynchronous reset mid-transaction
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 2'b00);
    chk("async_busy", busy, 1'b0);
    req_in_first  = 1'b0;
    req_in_second = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 33; i++) begin
      drive(vecs[i].r1, vecs[i].r2, vecs[i].ack);
      #1;
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_grant", i), grant, vecs[i].grant);
      chk($sformatf("v%0d_err", i), timeout_err, vecs[i].err);
      chk($sformatf("v%0d_id", i), timeout_id, vecs[i].id);
    end

    // watchdog disabled: master 1 never acked while master 2 waits
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0);
    errs0 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (timeout_err0) errs0++;
    end
    chk("wd0_errs", errs0, 0);
    chk("wd0_grant", grant0, 2'b10);
    chk("wd0_busy", busy0, 1'b1);
    chk("wd0_id", timeout_id0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
